// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader for the processor's program RAM.
//
// Frame: 0xA5, length N (words, 1..DEPTH), 2N payload bytes (high byte
// first), plus a checksum byte (XOR of payload) when PROG_LOADER_CHECKSUM_EN
// is defined. Default build (macro undefined) has no checksum stage.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   rx_valid      in   byte available
//   rx_data       in   byte value
//   rx_ready      out  byte accepted when rx_valid & rx_ready
//   ram_write_en0 out  program RAM port-0 write strobe (one cycle per word)
//   ram_addr0     out  port-0 write address, holds between strobes
//   ram_din0      out  port-0 write data, holds between strobes
//   start         out  processor run enable (level)
//   busy          out  frame in progress
//   error         out  sticky frame error, cleared only by reset
module prog_loader #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              ram_write_en0,
    output logic [ADDR_W-1:0] ram_addr0,
    output logic [DATA_W-1:0] ram_din0,
    output logic              start,
    output logic              busy,
    output logic              error
);

    localparam logic [7:0] HDR  = 8'hA5;
    localparam logic [8:0] MAXN = 9'(DEPTH);

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN, HI, LO, CHK, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN, HI, LO, DONE, ERR} state_t;
`endif

    state_t              state_q, state_d;
    logic [7:0]          n_q, n_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          hi_q, hi_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr0_q, addr0_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                start_q, start_d;
    logic                acc;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]          chk_q, chk_d;
`endif

    assign rx_ready      = ~reset;
    assign acc           = rx_valid & rx_ready;
    assign ram_write_en0 = we_q;
    assign ram_addr0     = addr0_q;
    assign ram_din0      = din_q;
    assign start         = start_q;
    assign error         = state_q == ERR;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign busy = state_q == LEN || state_q == HI || state_q == LO || state_q == CHK;
`else
    assign busy = state_q == LEN || state_q == HI || state_q == LO;
`endif

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        hi_d    = hi_q;
        we_d    = 1'b0;
        addr0_d = addr0_q;
        din_d   = din_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        if (acc) begin
            case (state_q)
                IDLE: state_d = rx_data == HDR ? LEN : IDLE;
                LEN: begin
                    if (rx_data == 8'd0 || {1'b0, rx_data} > MAXN) begin
                        state_d = ERR;
                    end else begin
                        n_d     = rx_data;
                        cnt_d   = 8'd0;
                        addr_d  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        chk_d   = 8'd0;
`endif
                        state_d = HI;
                    end
                end
                HI: begin
                    hi_d    = rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ rx_data;
`endif
                    state_d = LO;
                end
                LO: begin
                    we_d    = 1'b1;
                    addr0_d = addr_q;
                    din_d   = {hi_q, rx_data};
                    addr_d  = addr_q + ADDR_W'(1);
                    cnt_d   = cnt_q + 8'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ rx_data;
                    state_d = cnt_q + 8'd1 == n_q ? CHK : HI;
`else
                    state_d = cnt_q + 8'd1 == n_q ? DONE : HI;
`endif
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CHK: state_d = rx_data == chk_q ? DONE : ERR;
`endif
                DONE: state_d = rx_data == HDR ? LEN : DONE;
                ERR: state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
        // start lags DONE entry by one edge and drops on the edge leaving DONE
        start_d = state_q == DONE && state_d == DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= 8'd0;
            cnt_q   <= 8'd0;
            addr_q  <= '0;
            hi_q    <= 8'd0;
            we_q    <= 1'b0;
            addr0_q <= '0;
            din_q   <= '0;
            start_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            hi_q    <= hi_d;
            we_q    <= we_d;
            addr0_q <= addr0_d;
            din_q   <= din_d;
            start_q <= start_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

endmodule
